counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Shares one WIDTH-bit interval counter datapath between NUM_REQ requesters. Each requester asks for an interval of `len` clock cycles. The block grants requests round-robin, runs the shared counter for that many cycles, and then returns a one-cycle completion pulse tagged with the requester ID. It sits between software- or FSM-driven timing clients and the single counter resource they would otherwise duplicate.

## Interface
- NUM_REQ, default 4: number of requesters; 2..16.
- WIDTH, default 8: counter and interval-length width.
- ID_W, default $clog2(NUM_REQ): requester ID width (derived; not overridden).
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  reset; synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request.
- req_len  input  NUM_REQ*WIDTH  packed interval lengths; slice i belongs to requester i.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- busy  output  1  high while an interval is granted (RUN or DONE).
- grant  output  NUM_REQ  one-hot owner of the counter; 0 when IDLE.
- count  output  WIDTH  current counter value.
- done_valid  output  1  one-cycle completion pulse.
- done_id  output  ID_W  ID of the completed requester; valid with done_valid.
- abort  input  1  present only with the macro (see Configuration).
- done_abort  output  1  present only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid is high, select winner i by round-robin. Search starts at (last_id+1) mod NUM_REQ and proceeds upward with wrap.
  - req_ready[i]=1 this cycle; this is combinational from state, req_valid and last_id.
  - On the edge: cur_len<=req_len[i], cur_id<=i, last_id<=i, count<=0.
  - Next state is RUN if len!=0, otherwise DONE.
- RUN: grant[cur_id]=1.
  - If count==cur_len-1, next state is DONE and count holds.
  - Otherwise count<=count+1.
- DONE: done_valid=1 and done_id=cur_id for exactly one cycle; next state is IDLE. count holds its final value until the next accept.
- Requests are accepted only in IDLE. req_ready is 0 in RUN and DONE, regardless of req_valid.
- Requesters must hold req_valid and req_len stable until req_ready. Dropping req_valid before acceptance withdraws the request; this is legal.
- req_valid of the currently granted requester is ignored until the next IDLE.
- Counting is modulo 2^WIDTH. The maximum interval is 2^WIDTH-1; count never wraps because the terminal check precedes overflow.

## Timing
- Accept at cycle T:
  - RUN occupies cycles T+1..T+len, with count = 0..len-1.
  - done_valid is high at T+len+1.
  - The next accept is possible at T+len+2.
- len=0: done_valid at T+1; the next accept is possible at T+2.
- Values during reset and on the first cycle after it:
  - state=IDLE, count=0, grant=0, busy=0, done_valid=0, done_id=0.
  - req_ready=0 while reset is high; it is gated by reset.
  - last_id=NUM_REQ-1, so requester 0 wins first.
- Reset mid-RUN or mid-DONE: the interval is discarded and no done_valid is issued.
- Simultaneous requests: exactly one req_ready bit per accept; the remaining requesters are served in round-robin order in later IDLE cycles.
- No combinational path from req_len to any output. req_valid to req_ready is the only combinational path.

## Configuration
- COUNTER_ARBITER_ABORT_EN defined:
  - Adds the abort input and the done_abort output.
  - abort high in RUN: next state is DONE, count holds, and done_abort=1 alongside done_valid.
  - abort is ignored in IDLE and DONE.
  - done_abort=0 on normal completion and during reset.
- Macro undefined: neither port exists and every interval runs to completion.

## Structure
- Package counter_arbiter_pkg holds:
  - typedef enum logic [1:0] state_e {IDLE, RUN, DONE};
  - localparams DEFAULT_NUM_REQ=4 and DEFAULT_WIDTH=8.
- Sub-module rr_pick: a combinational round-robin picker.
  - Inputs: req vector and last_id.
  - Outputs: one-hot pick, pick_id, any.
  - It is reusable by other shared-resource blocks.

## Test plan
- Single request, requester 2 with len=5 accepted at T: count 0..4 over T+1..T+5; done_valid with done_id=2 at T+6; busy high T+1..T+6.
- All four requesters held with len=3 from reset: grants in order 0,1,2,3, then 0 again. Each accept is 5 cycles apart and each done_id matches its grant.
- len=0 from requester 1: done_valid at T+1 with done_id=1; count stays 0; grant stays 0 throughout.
- len=255: count reaches 254 with no wrap; done_valid at T+256.
- Reset asserted at count=3 of len=10: outputs return to reset values next cycle; no done_valid; requester 0 wins the next grant.
- With COUNTER_ARBITER_ABORT_EN, abort at count=2 of len=8: done_valid and done_abort both high on the following cycle; count=2.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg: shared types and defaults for the counter_arbiter block.
//   state_e         : arbiter/counter FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_NUM_REQ : default number of requesters
//   DEFAULT_WIDTH   : default counter / interval-length width
package counter_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 8;

endpackage

// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: request/grant/completion bundle for counter_arbiter.
//   req_valid  [NUM_REQ]        per-requester request
//   req_len    [NUM_REQ*WIDTH]  packed interval lengths, slice i = requester i
//   req_ready  [NUM_REQ]        one-hot accept strobe
//   busy                        interval granted (RUN or DONE)
//   grant      [NUM_REQ]        one-hot counter owner while running
//   count      [WIDTH]          shared counter value
//   done_valid / done_id        one-cycle completion pulse and its requester
//   abort / done_abort          only when COUNTER_ARBITER_ABORT_EN is defined
// Modports: master = requester side, slave = arbiter side.
interface counter_arbiter_if
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     busy;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         count;
  logic                     done_valid;
  logic [ID_W-1:0]          done_id;

`ifdef COUNTER_ARBITER_ABORT_EN
  logic abort;
  logic done_abort;

  modport master (
    output req_valid, req_len, abort,
    input  req_ready, busy, grant, count, done_valid, done_id, done_abort
  );
  modport slave (
    input  req_valid, req_len, abort,
    output req_ready, busy, grant, count, done_valid, done_id, done_abort
  );
`else
  modport master (
    output req_valid, req_len,
    input  req_ready, busy, grant, count, done_valid, done_id
  );
  modport slave (
    input  req_valid, req_len,
    output req_ready, busy, grant, count, done_valid, done_id
  );
`endif

endinterface

// File: rtl/counter_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, reusable by any shared resource.
//   req     [N]     request vector
//   last_id [ID_W]  previous winner; search starts at last_id+1 and wraps
//   pick    [N]     one-hot winner
//   pick_id [ID_W]  winner index
//   any             at least one request present
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  output logic [N-1:0]    pick,
  output logic [ID_W-1:0] pick_id,
  output logic            any
);

  int idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_id) + k) % N;
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        pick_id   = ID_W'(idx);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one WIDTH-bit interval counter between NUM_REQ
// requesters. Requests are granted round-robin in IDLE, the counter runs for
// req_len cycles in RUN, and DONE emits a one-cycle tagged completion pulse.
// Ports:
//   clk    clock, posedge
//   reset  synchronous, active-high
//   bus    counter_arbiter_if.slave (request, grant and completion signals)
// Optional feature macro: COUNTER_ARBITER_ABORT_EN adds abort / done_abort,
// letting a running interval be cut short.
//
// state | meaning
// IDLE  | waiting for a request; req_ready strobes the round-robin winner
// RUN   | counter owned by cur_id, counting 0..cur_len-1
// DONE  | one-cycle completion pulse for cur_id
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  counter_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID_RESET = ID_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, cur_len_q, len_sel;
  logic [ID_W-1:0]    cur_id_q, last_id_q, pick_id;
  logic [NUM_REQ-1:0] pick;
  logic               any, accept, terminal, abort_req;

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .req     (bus.req_valid),
    .last_id (last_id_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  assign len_sel  = bus.req_len[int'(pick_id)*WIDTH +: WIDTH];
  assign accept   = (state_q == IDLE) && any;
  // Checked before incrementing, so a full-scale length never wraps count.
  assign terminal = (count_q == cur_len_q - WIDTH'(1));

`ifdef COUNTER_ARBITER_ABORT_EN
  logic aborted_q;

  assign abort_req = bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (state_q == RUN && abort_req) begin
      aborted_q <= 1'b1;
    end
  end

  assign bus.done_abort = (state_q == DONE) && aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any) state_d = (len_sel != '0) ? RUN : DONE;
      RUN:  if (terminal || abort_req) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      cur_len_q <= '0;
      cur_id_q  <= '0;
      last_id_q <= LAST_ID_RESET;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cur_len_q <= len_sel;
        cur_id_q  <= pick_id;
        last_id_q <= pick_id;
        count_q   <= '0;
      end else if (state_q == RUN && state_d == RUN) begin
        count_q <= count_q + WIDTH'(1);
      end
    end
  end

  // req_ready is the only combinational output path (from req_valid).
  assign bus.req_ready  = (state_q == IDLE && !reset) ? pick : '0;
  assign bus.busy       = (state_q == RUN) || (state_q == DONE);
  assign bus.grant      = (state_q == RUN) ? (NUM_REQ'(1) << cur_id_q) : '0;
  assign bus.count      = count_q;
  assign bus.done_valid = (state_q == DONE);
  assign bus.done_id    = (state_q == DONE) ? cur_id_q : '0;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed scenarios plus randomized traffic. The
// stimulus side runs a transaction-level model (round-robin order, accept at
// T, done at T+len+1, next accept from T+len+2) and queues expected accepts
// and completions; a negedge monitor pops and compares them against the DUT.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef COUNTER_ARBITER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  counter_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  counter_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cycle; int id; } acc_t;
  typedef struct { int cycle; int id; int count; bit ab; } done_t;

  acc_t  acc_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;

  int   m_last, m_free, m_start, m_len, m_id, m_prev_final, m_acc_id;
  bit   m_have, m_rst, m_post_rst;
  logic abort_drv;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int final_of(input int len);
    return (len == 0) ? 0 : len - 1;
  endfunction

  function automatic logic [N*W-1:0] one_len(input int i, input int len);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = W'(len);
    return r;
  endfunction

  task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] lens,
                             input logic rst, input logic ab);
    int    w;
    int    len;
    done_t d;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req_valid = v;
    bus.req_len   = lens;
    abort_drv     = ab;
`ifdef COUNTER_ARBITER_ABORT_EN
    bus.abort = ab;
`endif
    m_acc_id   = -1;
    m_post_rst = m_rst && !rst;
    m_rst      = rst;
    if (rst) begin
      acc_q.delete();
      done_q.delete();
      m_have       = 1'b0;
      m_prev_final = 0;
      m_last       = N - 1;
      m_free       = cyc + 1;
    end else begin
      if (ABORT_EN && abort_drv && m_have && cyc > m_start && cyc <= m_start + m_len) begin
        m_len  = cyc - m_start;
        m_free = cyc + 2;
        d = done_q.pop_back();
        d.cycle = cyc + 1;
        d.count = m_len - 1;
        d.ab    = 1'b1;
        done_q.push_back(d);
      end
      if (cyc >= m_free && v != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
        len = int'(lens[w*W +: W]);
        if (m_have) m_prev_final = final_of(m_len);
        m_have  = 1'b1;
        m_start = cyc;
        m_len   = len;
        m_id    = w;
        m_last  = w;
        m_free  = cyc + len + 2;
        m_acc_id = w;
        acc_q.push_back('{cycle: cyc, id: w});
        done_q.push_back('{cycle: cyc + len + 1, id: w, count: final_of(len), ab: 1'b0});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle('0, '0, 1'b0, 1'b0);
  endtask

  task automatic hold_until_accept(input logic [N-1:0] v, input logic [N*W-1:0] lens);
    int k;
    k = 0;
    do begin
      drive_cycle(v, lens, 1'b0, 1'b0);
      k++;
    end while (m_acc_id < 0 && k < 300);
  endtask

  always @(negedge clk) begin
    int            n, ec;
    logic [N-1:0]  eg;
    bit            eb;
    acc_t          a;
    done_t         d;
    n = cyc;
    if (m_rst) begin
      chk("req_ready_in_reset", bus.req_ready, 0);
    end else begin
      if (m_have && n > m_start && n <= m_start + m_len) begin
        eg = N'(1) << m_id; eb = 1'b1; ec = n - m_start - 1;
      end else if (m_have && n == m_start + m_len + 1) begin
        eg = '0; eb = 1'b1; ec = final_of(m_len);
      end else if (m_have && n > m_start + m_len + 1) begin
        eg = '0; eb = 1'b0; ec = final_of(m_len);
      end else begin
        eg = '0; eb = 1'b0; ec = m_prev_final;
      end
      chk("grant", bus.grant, eg);
      chk("busy", bus.busy, eb);
      chk("count", bus.count, ec);

      while (acc_q.size() > 0 && acc_q[0].cycle < n) begin
        a = acc_q.pop_front();
        chk("accept_missed", 0, 1 << a.id);
      end
      if (acc_q.size() > 0 && acc_q[0].cycle == n) begin
        a = acc_q.pop_front();
        chk("req_ready", bus.req_ready, 1 << a.id);
      end else if (bus.req_ready != '0) begin
        chk("req_ready_unexpected", bus.req_ready, 0);
      end

      while (done_q.size() > 0 && done_q[0].cycle < n) begin
        d = done_q.pop_front();
        chk("done_missed", 0, 1);
      end
      if (done_q.size() > 0 && done_q[0].cycle == n) begin
        d = done_q.pop_front();
        chk("done_valid", bus.done_valid, 1);
        chk("done_id", bus.done_id, d.id);
`ifdef COUNTER_ARBITER_ABORT_EN
        chk("done_abort", bus.done_abort, d.ab);
`endif
      end else if (bus.done_valid) begin
        chk("done_valid_unexpected", bus.done_valid, 0);
      end

      if (m_post_rst) chk("done_id_after_reset", bus.done_id, 0);
    end
  end

  initial begin
    logic [N-1:0]   pv;
    logic [N*W-1:0] pl;
    logic           rst, ab;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_len   = '0;
    abort_drv     = 1'b0;
`ifdef COUNTER_ARBITER_ABORT_EN
    bus.abort = 1'b0;
`endif
    m_rst = 1'b1; m_post_rst = 1'b0; m_have = 1'b0;
    m_last = N - 1; m_free = 0; m_prev_final = 0; m_acc_id = -1;
    m_start = 0; m_len = 0; m_id = 0;

    repeat (3) drive_cycle('0, '0, 1'b1, 1'b0);

    // Single request from requester 2, len 5.
    hold_until_accept(4'b0100, one_len(2, 5));
    idle(8);

    // All four held with len 3 from reset: 0,1,2,3,0.
    repeat (2) drive_cycle('0, '0, 1'b1, 1'b0);
    repeat (26) drive_cycle(4'hF, {4{8'd3}}, 1'b0, 1'b0);
    idle(6);

    // Zero-length interval from requester 1.
    hold_until_accept(4'b0010, one_len(1, 0));
    idle(4);

    // Full-scale interval.
    hold_until_accept(4'b1000, one_len(3, 255));
    idle(260);

    // Reset while count=3 of len 10, then requester 0 must win.
    hold_until_accept(4'b0001, one_len(0, 10));
    idle(3);
    drive_cycle('0, '0, 1'b1, 1'b0);
    hold_until_accept(4'b0101, one_len(0, 2) | one_len(2, 4));
    idle(6);

    // Abort at count=2 of len 8; a second abort during DONE is ignored.
    if (ABORT_EN) begin
      hold_until_accept(4'b0010, one_len(1, 8));
      idle(2);
      drive_cycle('0, '0, 1'b0, 1'b1);
      drive_cycle('0, '0, 1'b0, 1'b1);
      drive_cycle('0, '0, 1'b0, 1'b1);
      idle(4);
    end

    pv = '0;
    pl = '0;
    repeat (1500) begin
      rst = ($urandom % 400) == 0;
      ab  = ABORT_EN && (($urandom % 40) == 0);
      drive_cycle(pv, pl, rst, ab);
      for (int i = 0; i < N; i++) if (m_acc_id == i) pv[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pv[i]) begin
          if (($urandom % 25) == 0) pv[i] = 1'b0;
        end else if (($urandom % 4) == 0) begin
          pv[i] = 1'b1;
          pl[i*W +: W] = (($urandom % 8) == 0) ? W'($urandom % 256) : W'($urandom % 6);
        end else begin
          pl[i*W +: W] = W'($urandom);
        end
      end
    end
    idle(300);

    chk("accept_queue_drained", acc_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
